nx_fifo_rd_prefetch: RTL and testbench
======================================

Name: nx_fifo_rd_prefetch

Overview:
Read-side prefetch stage placed directly downstream of an nx_fifo_ctrl instance and its storage RAM. It drives the controller's ren, absorbs the RAM read latency and presents FIFO contents as a valid/ready stream. A small in-order skid buffer lets the stream sustain one word per cycle under continuous out_ready, and no word is lost under backpressure.

Parameters:
DATA_WIDTH, 32, width of RAM read data and stream data.
RD_LATENCY, 1, RAM read latency in cycles, from fifo_ren to ram_rdata valid; legal values 1 or 2.
CAP, RD_LATENCY+1, skid buffer depth; derived, not to be overridden.

Ports:
clk  input  1  clock.
rst_n  input  1  reset; synchronous, active-low.
clear  input  1  synchronous flush; the same signal drives the controller's clear.
fifo_empty  input  1  empty flag from the FIFO controller.
fifo_ren  output  1  read strobe to the controller's ren; the RAM reads at the controller's rptr in the same cycle.
ram_rdata  input  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after fifo_ren.
out_valid  output  1  stream data valid.
out_ready  input  1  stream consumer ready.
out_data  output  DATA_WIDTH  stream data.
occupancy  output  2  in-flight reads plus skid entries, range 0..CAP.

Behaviour:
- Definitions:
  - pop = out_valid & out_ready.
  - inflight = number of set bits in an RD_LATENCY-deep valid shift pipe.
  - skid_cnt = number of skid entries held.
  - occupancy = inflight + skid_cnt (registered state).
- Issue rule: fifo_ren = rst_n & ~clear & ~fifo_empty & ((occupancy - pop) < CAP). This is combinational from the registered state, fifo_empty, clear, out_ready and rst_n.
- fifo_ren never asserts while fifo_empty=1, so the controller's underflow must never assert.
- Valid pipe: bit 0 is loaded with fifo_ren; the pipe shifts each cycle. When the last stage is set, ram_rdata is written into the skid buffer at the write index in that cycle.
- Skid buffer:
  - circular, CAP entries, wr_idx/rd_idx wrap modulo CAP;
  - out_valid = (skid_cnt != 0); out_data = entry at rd_idx;
  - pop advances rd_idx;
  - simultaneous write and pop leaves skid_cnt unchanged.
- The CAP sizing guarantees a skid write never finds the buffer full. An RTL assertion must flag any write while skid_cnt == CAP with no pop.
- Latency, with out_ready=1 and the skid buffer empty:
  - fifo_ren in cycle T;
  - ram_rdata sampled in cycle T+RD_LATENCY;
  - out_valid=1 in cycle T+RD_LATENCY+1.
- Throughput: one word per cycle sustained while the FIFO is non-empty and out_ready=1.
- Stream rules:
  - Once out_valid=1, out_valid and out_data hold stable until pop.
  - Order of words equals FIFO order.
  - out_valid does not depend combinationally on out_ready.
- clear:
  - fifo_ren=0 in that cycle;
  - next cycle the valid pipe, skid_cnt, indices and occupancy are all 0 and out_valid=0;
  - RAM data returning for reads issued before or during the clear cycle is discarded.
- Reset (rst_n=0 sampled at clk):
  - same state as clear: out_valid=0, occupancy=0, indices 0;
  - fifo_ren forced 0 while rst_n=0;
  - out_data is don't-care while out_valid=0; skid data registers are not reset.
- Reset or clear mid-stream drops all buffered and in-flight words; no partial word is ever presented.

Test Plan:
- Reset: hold rst_n=0 3 cycles with fifo_empty=0, out_ready=1 -> fifo_ren=0 throughout; out_valid=0 and occupancy=0 on the first cycle after release; fifo_ren=1 on that cycle.
- Single word, RD_LATENCY=1: fifo_empty=0 for cycle 0 only, ram_rdata=32'hA5A5_0001 in cycle 1 -> fifo_ren=1 cycle 0 only; out_valid=1 with out_data=32'hA5A5_0001 in cycle 2; out_valid=0 cycle 3.
- Streaming: 8 words 32'h1..32'h8 in the FIFO, out_ready=1 -> fifo_ren high 8 consecutive cycles; out_valid high 8 consecutive cycles starting 2 cycles later; data 1..8 in order; no bubbles.
- Backpressure: 5 words in the FIFO, out_ready=0 -> exactly CAP=2 fifo_ren pulses, then fifo_ren=0 and occupancy=2; out_data stable at word 1. Raise out_ready -> words 1..5 delivered in order, none dropped or duplicated.
- Clear mid-flight: fifo_ren in cycle T, clear=1 in cycle T+1 -> fifo_ren=0 in T+1; returned data discarded; out_valid=0 and occupancy=0 in T+2.
- RD_LATENCY=2 build: repeat the streaming and backpressure scenarios -> first out_valid 3 cycles after the first fifo_ren; backpressure stall occupancy=3; full-rate streaming maintained.

Source files
------------

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch for nx_fifo_ctrl: issues ren, absorbs RAM read latency and
// presents FIFO words as a valid/ready stream through a small in-order skid buffer.
module nx_fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam int CAP = RD_LATENCY + 1;
  localparam int IW  = $clog2(CAP);

  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0] skid_q [CAP];
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop;
  logic                  ren;
  logic                  skid_wr;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == IW'(CAP - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = skid_q[rd_idx_q];
  assign occupancy = occ_q;
  assign skid_wr   = vld_pipe_q[RD_LATENCY-1];

  // Subtracting this cycle's pop lets a full buffer keep issuing at full rate.
  assign ren = rst_n & ~clear & ~fifo_empty &
               (({1'b0, occ_q} - {2'b00, pop}) < 3'(CAP));
  assign fifo_ren = ren;

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = ren;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
    wr_idx_d = skid_wr ? idx_inc(wr_idx_q) : wr_idx_q;
    rd_idx_d = pop ? idx_inc(rd_idx_q) : rd_idx_q;
    cnt_d    = cnt_q + 2'(skid_wr) - 2'(pop);
    occ_d    = occ_q + 2'(ren) - 2'(pop);
    if (clear) begin
      vld_pipe_d = '0;
      wr_idx_d   = '0;
      rd_idx_d   = '0;
      cnt_d      = '0;
      occ_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      cnt_q      <= '0;
      occ_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
    end
  end

  // Data storage carries no reset; out_valid gates its use.
  always_ff @(posedge clk) begin
    if (skid_wr) begin
      skid_q[wr_idx_q] <= ram_rdata;
    end
  end

  a_no_skid_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_wr && (cnt_q == 2'(CAP)) && !pop));

endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Bench for nx_fifo_rd_prefetch: drives a latency-1 and a latency-2 instance side by
// side from small FIFO/RAM models and checks directed scenarios against fixed timings.
module tb_nx_fifo_rd_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, out_ready, mrst;
  logic        fe [2];
  logic        ren [2];
  logic        ov [2];
  logic [31:0] rdat [2];
  logic [31:0] od [2];
  logic [1:0]  occ [2];
  logic [31:0] mem [2][16];
  logic [4:0]  wptr [2];
  logic [4:0]  rptr [2];
  logic [31:0] rs0 [2];
  logic [31:0] rs1 [2];
  int          got [2];

  int checks   = 0;
  int failures = 0;

  nx_fifo_rd_prefetch #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fe[0]), .fifo_ren(ren[0]),
    .ram_rdata(rdat[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0])
  );

  nx_fifo_rd_prefetch #(.DATA_WIDTH(32), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fe[1]), .fifo_ren(ren[1]),
    .ram_rdata(rdat[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1])
  );

  assign fe[0]   = (wptr[0] == rptr[0]);
  assign fe[1]   = (wptr[1] == rptr[1]);
  assign rdat[0] = rs0[0];
  assign rdat[1] = rs1[1];

  // FIFO controller read pointer plus RAM read pipeline
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mrst) rptr[k] <= '0;
      else if (ren[k]) rptr[k] <= rptr[k] + 5'd1;
      rs0[k] <= mem[k][rptr[k][3:0]];
      rs1[k] <= rs0[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  task automatic push(input int k, input logic [31:0] w);
    mem[k][wptr[k][3:0]] = w;
    wptr[k] = wptr[k] + 5'd1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    mrst      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wptr[k] = '0;
      got[k]  = 0;
    end
    next_cyc();
    mrst = 1'b0;

    // Reset with a non-empty FIFO, then stream 8 words
    for (int k = 0; k < 2; k++)
      for (int w = 1; w <= 8; w++) push(k, 32'(w));
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("rst_ren_L%0d_r%0d", k+1, r), ren[k], 0);
      next_cyc();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (c == 0) chk($sformatf("rel_occ_L%0d", k+1), occ[k], 0);
        chk($sformatf("str_ren_L%0d_c%0d", k+1, c), ren[k], (c < 8));
        chk($sformatf("str_vld_L%0d_c%0d", k+1, c), ov[k], (c >= k+2 && c <= k+9));
        if (c >= k+2 && c <= k+9)
          chk($sformatf("str_dat_L%0d_c%0d", k+1, c), od[k], 32'(c - (k+1)));
      end
      next_cyc();
    end

    // Single word
    for (int k = 0; k < 2; k++) push(k, 32'hA5A5_0001);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("one_ren_L%0d_c%0d", k+1, c), ren[k], (c == 0));
        chk($sformatf("one_vld_L%0d_c%0d", k+1, c), ov[k], (c == k+2));
        if (c == k+2) chk($sformatf("one_dat_L%0d", k+1), od[k], 32'hA5A5_0001);
      end
      next_cyc();
    end

    // Backpressure: stall fills exactly CAP entries, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 5; w++) push(k, 32'h11 + 32'(w));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("bp_ren_L%0d_c%0d", k+1, c), ren[k], (c < k+2));
        if (c >= k+2) begin
          chk($sformatf("bp_vld_L%0d_c%0d", k+1, c), ov[k], 1);
          chk($sformatf("bp_dat_L%0d_c%0d", k+1, c), od[k], 32'h11);
        end
        if (c == 7) chk($sformatf("bp_occ_L%0d", k+1), occ[k], 32'(k+2));
      end
      next_cyc();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          chk($sformatf("bp_drain_L%0d_n%0d", k+1, got[k]), od[k], 32'h11 + 32'(got[k]));
          got[k]++;
        end
      end
      next_cyc();
    end
    for (int k = 0; k < 2; k++) chk($sformatf("bp_count_L%0d", k+1), got[k], 5);

    // Clear one cycle after an issued read
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 3; w++) push(k, 32'h21 + 32'(w));
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("clr_ren0_L%0d", k+1), ren[k], 1);
    next_cyc();
    clear = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("clr_ren1_L%0d", k+1), ren[k], 0);
    next_cyc();
    clear = 1'b0;
    for (int k = 0; k < 2; k++) wptr[k] = rptr[k];
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("clr_vld_L%0d_c%0d", k+1, c), ov[k], 0);
        if (c == 2) chk($sformatf("clr_occ_L%0d", k+1), occ[k], 0);
      end
      next_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
